dot_matrix_game_ctrl: RTL

Game-status sequencer for the dual 8x8 dot-matrix display of the tic-tac-toe board.
- Tracks whose turn it is and forfeits a turn on timeout.
- Latches the game result and runs the end-of-game blink sequence.
- Locks board input while a result is shown, then handles restart with alternating first player.
- Outputs feed the display's whosTurn/gameend/toggle inputs directly, replacing the display's free-running toggle.

---
 rtl/dot_matrix_game_ctrl_pkg.sv | 40 ++++
 rtl/dot_matrix_game_ctrl_if.sv | 21 ++
 rtl/dot_matrix_game_ctrl_tick_sync.sv | 29 ++
 rtl/dot_matrix_game_ctrl.sv | 108 ++++++++++
 4 files changed

// File: rtl/dot_matrix_game_ctrl_pkg.sv
// Shared codes for the tic-tac-toe game-status sequencer and the dot-matrix display.
// gameend and player encodings are consumed unchanged by the display module.
package dot_matrix_game_ctrl_pkg;

  typedef enum logic [1:0] {
    GE_PLAY = 2'b00,
    GE_OWIN = 2'b01,
    GE_XWIN = 2'b10,
    GE_DRAW = 2'b11
  } gameend_t;

  typedef enum logic {
    P_O = 1'b0,
    P_X = 1'b1
  } player_t;

  typedef enum logic [1:0] {
    TURN_O    = 2'd0,
    TURN_X    = 2'd1,
    END_BLINK = 2'd2,
    END_HOLD  = 2'd3
  } state_t;

  localparam int TIMER_W = 5;
  localparam int BLINK_W = 8;

  // Counters saturate at all-ones instead of wrapping back to zero.
  function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  function automatic logic [BLINK_W-1:0] blink_inc(input logic [BLINK_W-1:0] b);
    return (b == '1) ? b : b + 1'b1;
  endfunction

  function automatic state_t turn_state(input player_t p);
    return (p == P_X) ? TURN_X : TURN_O;
  endfunction

endpackage

// File: rtl/dot_matrix_game_ctrl_if.sv
// Board/display handshake bundle: move and restart requests in, game status out.
interface dot_matrix_game_ctrl_if;
  logic       move_valid;
  logic [1:0] move_result;
  logic       restart;
  logic       whosTurn;
  logic [1:0] gameend;
  logic       toggle;
  logic       move_lock;
  logic       timeout_pulse;

  modport master (
    output move_valid, move_result, restart,
    input  whosTurn, gameend, toggle, move_lock, timeout_pulse
  );

  modport slave (
    input  move_valid, move_result, restart,
    output whosTurn, gameend, toggle, move_lock, timeout_pulse
  );
endinterface

// File: rtl/dot_matrix_game_ctrl_tick_sync.sv
// Synchronizes a slow square wave into the clock domain and emits a one-cycle
// pulse on each rising edge; the wave is only ever sampled as data.
module dot_matrix_game_ctrl_tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic slow_in,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= slow_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  // sync_p2 is the previous synchronized sample for edge detection.
  assign tick = sync_p1 & ~sync_p2;

endmodule

// File: rtl/dot_matrix_game_ctrl.sv
// Game-status sequencer: turn tracking with forfeit on timeout, result latch,
// end-of-game blink/hold, and restart with alternating first player.
module dot_matrix_game_ctrl
  import dot_matrix_game_ctrl_pkg::*;
#(
  parameter int TURN_TIMEOUT = 20,
  parameter int BLINK_TICKS  = 6
) (
  input  logic                   clk_10000Hz,
  input  logic                   reset,
  input  logic                   clk_2Hz,
  dot_matrix_game_ctrl_if.slave  bus
);

  localparam bit                 TIMEOUT_EN = (TURN_TIMEOUT != 0);
  localparam logic [TIMER_W-1:0] TIMEOUT_L  = TIMER_W'(TURN_TIMEOUT);
  localparam logic [BLINK_W-1:0] BLINK_L    = BLINK_W'(BLINK_TICKS);

  logic               tick;
  state_t             state;
  player_t            first_player;
  player_t            other_player;
  logic [TIMER_W-1:0] turn_timer;
  logic [TIMER_W-1:0] timer_nxt;
  logic [BLINK_W-1:0] blink_cnt;
  logic [BLINK_W-1:0] blink_nxt;

  dot_matrix_game_ctrl_tick_sync u_tick_sync (
    .clk     (clk_10000Hz),
    .reset   (reset),
    .slow_in (clk_2Hz),
    .tick    (tick)
  );

  assign other_player = (state == TURN_O) ? P_X : P_O;
  assign timer_nxt    = timer_inc(turn_timer);
  assign blink_nxt    = blink_inc(blink_cnt);

  always_ff @(posedge clk_10000Hz or negedge reset) begin
    if (!reset) begin
      state             <= TURN_O;
      first_player      <= P_O;
      turn_timer        <= '0;
      blink_cnt         <= '0;
      bus.whosTurn      <= P_O;
      bus.gameend       <= GE_PLAY;
      bus.toggle        <= 1'b0;
      bus.move_lock     <= 1'b0;
      bus.timeout_pulse <= 1'b0;
    end else begin
      bus.timeout_pulse <= 1'b0;
      // restart overrides everything else in the same cycle
      if (bus.restart) begin
        first_player  <= player_t'(~first_player);
        state         <= turn_state(player_t'(~first_player));
        bus.whosTurn  <= ~first_player;
        bus.gameend   <= GE_PLAY;
        bus.toggle    <= 1'b0;
        bus.move_lock <= 1'b0;
        turn_timer    <= '0;
        blink_cnt     <= '0;
      end else begin
        case (state)
          TURN_O, TURN_X: begin
            // a move takes priority over a coincident tick, which is dropped
            if (bus.move_valid) begin
              turn_timer <= '0;
              if (bus.move_result == GE_PLAY) begin
                state        <= turn_state(other_player);
                bus.whosTurn <= other_player;
              end else begin
                state         <= END_BLINK;
                bus.gameend   <= bus.move_result;
                bus.move_lock <= 1'b1;
                bus.toggle    <= 1'b1;
                blink_cnt     <= '0;
              end
            end else if (tick) begin
              if (TIMEOUT_EN && (timer_nxt == TIMEOUT_L)) begin
                state             <= turn_state(other_player);
                bus.whosTurn      <= other_player;
                turn_timer        <= '0;
                bus.timeout_pulse <= 1'b1;
              end else begin
                turn_timer <= timer_nxt;
              end
            end
          end
          END_BLINK: begin
            if (tick) begin
              blink_cnt <= blink_nxt;
              if (blink_nxt == BLINK_L) begin
                state      <= END_HOLD;
                bus.toggle <= 1'b1;
              end else begin
                bus.toggle <= ~bus.toggle;
              end
            end
          end
          END_HOLD: begin
          end
          default: state <= TURN_O;
        endcase
      end
    end
  end

endmodule
